// File: rtl/pipe_sched_pkg.sv
// Shared types and the round-robin pick helper for the pipeline schedulers.
package pipe_sched_pkg;

  localparam int unsigned R_DEF  = 4;
  localparam int unsigned W_DEF  = 32;
  localparam int unsigned TW_DEF = $clog2(R_DEF);
  localparam int unsigned MAX_R  = 32;

  typedef logic [TW_DEF-1:0] tag_t;

  typedef struct packed {
    tag_t             tag;
    logic [W_DEF-1:0] payload;
  } pipe_word_t;

  // One-hot of the first set elig bit scanning ptr, ptr+1, ... wrapping at n-1 -> 0.
  function automatic logic [MAX_R-1:0] rr_pick(input logic [MAX_R-1:0] elig,
                                               input int unsigned      ptr,
                                               input int unsigned      n);
    logic [MAX_R-1:0] g;
    logic             found;
    int unsigned      idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_R; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && elig[idx]) begin
          g[idx] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/pipe_rr_arb.sv
// R-way round-robin picker; pointer moves past the winner only on a handshake.
module pipe_rr_arb
  import pipe_sched_pkg::*;
#(
  parameter int unsigned R  = 4,
  parameter int unsigned TW = $clog2(R)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [R-1:0]  elig,
  input  logic          advance,
  output logic [R-1:0]  grant,
  output logic [TW-1:0] win,
  output logic          any
);

  logic [TW-1:0]    ptr_q, ptr_d;
  logic [MAX_R-1:0] elig_ext;
  logic [MAX_R-1:0] pick;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    elig_ext        = '0;
    elig_ext[R-1:0] = elig;
    pick            = rr_pick(elig_ext, 32'(ptr_q), R);
    grant           = pick[R-1:0];
    any             = |elig;
    win             = '0;
    for (int i = 0; i < R; i++) begin
      if (grant[i]) win = TW'(i);
    end
  end

  // Explicit wrap keeps non-power-of-two R correct.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = (win == TW'(R - 1)) ? '0 : win + TW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, active-high.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pipe_rr_sched.sv
// Round-robin front/back end for a shared in-order pipeline: tags, caps and steers words.
module pipe_rr_sched
  import pipe_sched_pkg::*;
#(
  parameter int unsigned R            = 4,
  parameter int unsigned W            = 32,
  parameter int unsigned TW           = $clog2(R),
  parameter int unsigned PW           = W + TW,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    req_vld,
  input  logic [R*W-1:0]  req_data,
  output logic [R-1:0]    req_accept,
  output logic [PW-1:0]   pipe_in,
  output logic            pipe_in_vld,
  input  logic            pipe_in_accept,
  input  logic [PW-1:0]   pipe_out_r,
  input  logic            pipe_out_vld_r,
  output logic [R-1:0]    rsp_vld_r,
  output logic [W-1:0]    rsp_data_r,
  output logic [R*CW-1:0] inflight_r,
  output logic            idle,
  output logic            err_r
);

  logic [R-1:0][CW-1:0] inflight_q, inflight_d;
  logic [R-1:0]         rsp_vld_q, rsp_vld_d;
  logic [W-1:0]         rsp_data_q, rsp_data_d;
  logic                 err_q, err_d;

  logic [R-1:0]  elig, grant, dec, underflow, eff_dec;
  logic [TW-1:0] win, out_tag;
  logic          any, handshake, tag_bad;
  logic [W-1:0]  sel_data;

  always_comb begin
    for (int i = 0; i < R; i++) begin
      elig[i] = req_vld[i] & (inflight_q[i] < CW'(MAX_INFLIGHT));
    end
  end

  assign handshake = any & pipe_in_accept;

  pipe_rr_arb #(.R(R), .TW(TW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .elig    (elig),
    .advance (handshake),
    .grant   (grant),
    .win     (win),
    .any     (any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < R; i++) begin
      if (grant[i]) sel_data = req_data[i*W +: W];
    end
  end

  assign pipe_in_vld = any;
  assign pipe_in     = any ? {win, sel_data} : '0;
  assign req_accept  = grant & {R{pipe_in_accept}};

  // A returning word that underflows or carries an out-of-range tag is dropped and flagged.
  assign out_tag = pipe_out_r[PW-1:W];
  assign tag_bad = (32'(out_tag) >= R);

  always_comb begin
    for (int i = 0; i < R; i++) begin
      dec[i]       = pipe_out_vld_r & ~tag_bad & (out_tag == TW'(i));
      underflow[i] = dec[i] & (inflight_q[i] == '0);
    end
    eff_dec = dec & ~underflow;
  end

  always_comb begin
    inflight_d = inflight_q;
    for (int i = 0; i < R; i++) begin
      case ({req_accept[i], eff_dec[i]})
        2'b10:   inflight_d[i] = inflight_q[i] + CW'(1);
        2'b01:   inflight_d[i] = inflight_q[i] - CW'(1);
        default: inflight_d[i] = inflight_q[i];
      endcase
    end
    rsp_vld_d  = eff_dec;
    rsp_data_d = pipe_out_vld_r ? pipe_out_r[W-1:0] : rsp_data_q;
    err_d      = err_q | (pipe_out_vld_r & (tag_bad | (|underflow)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  assign rsp_vld_r  = rsp_vld_q;
  assign rsp_data_r = rsp_data_q;
  assign inflight_r = inflight_q;
  assign err_r      = err_q;
  assign idle       = (inflight_q == '0) & ~(|rsp_vld_q);

endmodule

// File: tb/tb_pipe_rr_sched.sv
// Randomized bench for pipe_rr_sched against a queue-based behavioural model.
module tb_pipe_rr_sched;
  import pipe_sched_pkg::*;

  localparam int R    = 4;
  localparam int W    = 32;
  localparam int TW   = 2;
  localparam int PW   = W + TW;
  localparam int MAXI = 4;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [R-1:0]    req_vld;
  logic [R*W-1:0]  req_data;
  logic [R-1:0]    req_accept;
  logic [PW-1:0]   pipe_in;
  logic            pipe_in_vld;
  logic            pipe_in_accept;
  logic [PW-1:0]   pipe_out_r;
  logic            pipe_out_vld_r;
  logic [R-1:0]    rsp_vld_r;
  logic [W-1:0]    rsp_data_r;
  logic [R*CW-1:0] inflight_r;
  logic            idle;
  logic            err_r;

  always #5 clk = ~clk;

  pipe_rr_sched #(.R(R), .W(W), .MAX_INFLIGHT(MAXI)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_vld        (req_vld),
    .req_data       (req_data),
    .req_accept     (req_accept),
    .pipe_in        (pipe_in),
    .pipe_in_vld    (pipe_in_vld),
    .pipe_in_accept (pipe_in_accept),
    .pipe_out_r     (pipe_out_r),
    .pipe_out_vld_r (pipe_out_vld_r),
    .rsp_vld_r      (rsp_vld_r),
    .rsp_data_r     (rsp_data_r),
    .inflight_r     (inflight_r),
    .idle           (idle),
    .err_r          (err_r)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: outstanding counts, rotating start point, sticky error, last response.
  int           m_cnt[R];
  int           m_ptr;
  logic         m_err;
  logic [R-1:0] m_rsp_vld;
  logic [W-1:0] m_rsp_data;
  pipe_word_t   pipe_q[$];
  int           acc_seen[R];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs();
    logic [R*CW-1:0] exp_inf;
    logic            exp_idle;
    exp_idle = (m_rsp_vld == '0);
    for (int i = 0; i < R; i++) begin
      exp_inf[i*CW +: CW] = CW'(m_cnt[i]);
      if (m_cnt[i] != 0) exp_idle = 1'b0;
    end
    check("inflight_r", 64'(inflight_r), 64'(exp_inf));
    check("rsp_vld_r",  64'(rsp_vld_r),  64'(m_rsp_vld));
    check("rsp_data_r", 64'(rsp_data_r), 64'(m_rsp_data));
    check("err_r",      64'(err_r),      64'(m_err));
    check("idle",       64'(idle),       64'(exp_idle));
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic [R-1:0] vld, input logic acc, input int pop_pct,
                      input bit inj = 1'b0, input logic [PW-1:0] inj_word = '0);
    int            win;
    int            idx;
    int            t;
    logic [PW-1:0] exp_pin;
    logic [R-1:0]  exp_acc;
    pipe_word_t    w;
    check_regs();
    req_vld        = vld;
    pipe_in_accept = acc;
    for (int i = 0; i < R; i++) req_data[i*W +: W] = $urandom;
    pipe_out_vld_r = 1'b0;
    pipe_out_r     = '0;
    if (inj) begin
      pipe_out_vld_r = 1'b1;
      pipe_out_r     = inj_word;
    end else if (pipe_q.size() > 0 && $urandom_range(99) < pop_pct) begin
      pipe_out_vld_r = 1'b1;
      pipe_out_r     = pipe_q.pop_front();
    end
    #1;
    win = -1;
    for (int k = 0; k < R; k++) begin
      idx = (m_ptr + k) % R;
      if (win < 0 && vld[idx] && m_cnt[idx] < MAXI) win = idx;
    end
    exp_pin = '0;
    exp_acc = '0;
    if (win >= 0) begin
      exp_pin = {TW'(win), req_data[win*W +: W]};
      if (acc) exp_acc[win] = 1'b1;
    end
    check("pipe_in_vld", 64'(pipe_in_vld), 64'(win >= 0));
    check("pipe_in",     64'(pipe_in),     64'(exp_pin));
    check("req_accept",  64'(req_accept),  64'(exp_acc));
    for (int i = 0; i < R; i++) acc_seen[i] += int'(req_accept[i]);
    m_rsp_vld = '0;
    if (pipe_out_vld_r) begin
      t          = int'(pipe_out_r[PW-1:W]);
      m_rsp_data = pipe_out_r[W-1:0];
      if (t >= R || m_cnt[t] == 0) m_err = 1'b1;
      else begin
        m_cnt[t]--;
        m_rsp_vld[t] = 1'b1;
      end
    end
    if (win >= 0 && acc) begin
      m_cnt[win]++;
      m_ptr     = (win + 1) % R;
      w.tag     = TW'(win);
      w.payload = req_data[win*W +: W];
      pipe_q.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_vld        = '0;
    pipe_in_accept = 1'b0;
    pipe_out_vld_r = 1'b0;
    pipe_out_r     = '0;
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    m_ptr      = 0;
    m_err      = 1'b0;
    m_rsp_vld  = '0;
    m_rsp_data = '0;
    for (int i = 0; i < R; i++) begin
      m_cnt[i]    = 0;
      acc_seen[i] = 0;
    end
    pipe_q.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && pipe_q.size() > 0; i++) step('0, 1'b0, 100);
    step('0, 1'b0, 0);
  endtask

  initial begin
    rst      = 1'b1;
    req_data = '0;
    @(negedge clk);
    do_reset();

    // Single requester round trip
    step(4'b0001, 1'b1, 0);
    repeat (3) step('0, 1'b0, 0);
    step('0, 1'b0, 100);
    check("single_rsp", 64'(rsp_vld_r), 64'(4'b0001));
    step('0, 1'b0, 0);
    check("single_idle", 64'(idle), 64'(1));

    // Fairness: 8 back-to-back grants, two each
    do_reset();
    repeat (8) step(4'b1111, 1'b1, 0);
    for (int i = 0; i < R; i++) check($sformatf("fair_%0d", i), 64'(acc_seen[i]), 64'(2));
    drain();

    // Stall holds the winner and pointer
    repeat (5) step(4'b1111, 1'b0, 0);
    repeat (2) step(4'b1111, 1'b1, 0);
    drain();

    // In-flight cap on requester 2, then one return reopens it
    do_reset();
    repeat (6) step(4'b0100, 1'b1, 0);
    check("cap_full", 64'(inflight_r[2*CW +: CW]), 64'(MAXI));
    check("cap_accepts", 64'(acc_seen[2]), 64'(MAXI));
    step(4'b0100, 1'b1, 100);
    repeat (2) step(4'b0100, 1'b1, 0);
    drain();

    // Simultaneous increment and decrement
    do_reset();
    step(4'b0010, 1'b1, 0);
    step(4'b0010, 1'b1, 100);
    drain();
    step(4'b1000, 1'b1, 0);
    step(4'b0001, 1'b1, 100);
    drain();

    // Underflow error is sticky and drops the response
    do_reset();
    step('0, 1'b0, 0, 1'b1, {2'd2, 32'h0000_1234});
    step('0, 1'b0, 0);
    check("err_sticky", 64'(err_r), 64'(1));

    // Random traffic with a reset in the middle
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      step(R'($urandom), ($urandom_range(99) < 75), 50);
    end
    drain();
    check_regs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
